// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with reset/trap vectors, stall hold,
// prioritised redirects (trap > mret > branch), exception-PC capture and a
// RUN/HALTED state machine for ebreak-style halts.
module pc_unit #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned          INC          = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            flush,
  output logic [XLEN-1:0] epc,
  output logic            halted,
  output logic            misalign
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // Clear the two low address bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    word_align = {addr[XLEN-1:2], 2'b00};
  endfunction

  state_t            state_r, state_s;
  logic [XLEN-1:0]   pc_r, pc_s;
  logic [XLEN-1:0]   epc_r, epc_s;
  logic              misalign_r, misalign_s;
  logic              br_win_s;

  // Next-state, next-PC and flush resolution in priority order.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    epc_s      = epc_r;
    misalign_s = 1'b0;
    br_win_s   = 1'b0;

    if (trap) begin
      pc_s    = TRAP_VECTOR;
      epc_s   = word_align(trap_pc);
      state_s = RUN;
    end else if (mret) begin
      pc_s    = epc_r;
      state_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (br_taken) begin
            br_win_s   = 1'b1;
            pc_s       = word_align(br_target);
            misalign_s = (br_target[1:0] != 2'b00);
          end else if (halt) begin
            state_s = HALTED;
          end else if (stall) begin
            pc_s = pc_r;
          end else begin
            pc_s = pc_r + XLEN'(INC);
          end
        end
        HALTED: begin
          // A branch resolved while halted is dropped; only resume restarts fetch.
          if (resume) begin
            state_s = RUN;
          end else begin
            state_s = HALTED;
          end
        end
        default: begin
          state_s = RUN;
        end
      endcase
    end

    flush = (trap | mret | br_win_s) & ~rst;
  end

  // State registers with synchronous reset overriding every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      pc_r       <= RESET_VECTOR;
      epc_r      <= {XLEN{1'b0}};
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      epc_r      <= epc_s;
      misalign_r <= misalign_s;
    end
  end

  assign pc_out   = pc_r;
  assign epc      = epc_r;
  assign halted   = (state_r == HALTED);
  assign misalign = misalign_r;
  assign pc_valid = (state_r == RUN) & ~stall;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined RISC-V core. It replaces the plain PC register in the IF stage. It adds a configurable width, reset and trap vectors, a stall hold, and prioritised redirects (branch/jump, trap, mret). It also provides an exception-PC register and a RUN/HALTED state machine for ebreak-style halts. It drives the instruction-memory address and issues the IF/ID and ID/EX flush request on every redirect.

## Interface
- XLEN, 32: PC and address width.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset. Must be 4-byte aligned.
- TRAP_VECTOR, 32'h0000_0100: PC value loaded on trap. Must be 4-byte aligned.
- INC, 4: sequential increment in bytes.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold request; PC keeps its value.
- br_taken  in  1  EX-stage branch/jump resolved taken.
- br_target  in  XLEN  EX-stage target address.
- trap  in  1  exception raised at MEM/WB.
- trap_pc  in  XLEN  PC of the faulting instruction.
- mret  in  1  return from trap.
- halt  in  1  retire-stage halt request (ebreak).
- resume  in  1  external resume request.
- pc_out  out  XLEN  current fetch address.
- pc_valid  out  1  pc_out is a fetch to be issued.
- flush  out  1  kill younger instructions in IF/ID and ID/EX.
- epc  out  XLEN  saved exception PC.
- halted  out  1  state machine is HALTED.
- misalign  out  1  one-cycle pulse when a redirect target has [1:0] != 0.

## Operation
- State: pc register (XLEN), epc register (XLEN), FSM {RUN, HALTED}, misalign flag.
- Next-PC priority, highest first:
  - rst: pc = RESET_VECTOR, epc = 0, FSM = RUN.
  - trap: pc = TRAP_VECTOR, epc = trap_pc with [1:0] cleared.
  - mret: pc = epc.
  - br_taken: pc = br_target with [1:0] cleared.
  - halt: pc holds, FSM to HALTED.
  - stall, or FSM = HALTED: pc holds.
  - otherwise: pc = pc + INC, modulo 2^XLEN.
- Redirects (trap, mret, br_taken) override stall and halt in the same cycle.
- trap and mret are both accepted in HALTED. Either one returns the FSM to RUN. br_taken is ignored while HALTED.
- In HALTED, resume moves the FSM to RUN on the next edge. The PC is unchanged, and fetch restarts at the held address.
- flush is combinational: (trap | mret | br_taken) & ~rst & ~(br_taken-only while HALTED).
- misalign is registered. It is set for one cycle when the winning redirect is br_taken and br_target[1:0] != 0. The redirect still happens, with [1:0] cleared.
- pc_valid = (FSM == RUN) & ~stall.

## Timing
- Reset values after an rst edge:
  - pc_out = RESET_VECTOR
  - epc = 0
  - halted = 0
  - misalign = 0
  - pc_valid = ~stall
  - flush = 0 while rst is high
- Redirect latency: redirect input in cycle N gives the new pc_out in cycle N+1. flush is high in cycle N only.
- Stall latency: stall in cycle N keeps pc_out in N+1 equal to its value in N.
- Halt latency: halt in cycle N gives halted = 1 and pc_valid = 0 from N+1.
- Resume latency: resume in cycle N gives halted = 0 from N+1.
- Wrap-around: pc = 2^XLEN − INC increments to 0, with no flag.
- Simultaneous events resolve by the priority list.
  - trap and br_taken together: trap wins, epc is captured, br_target is discarded.
  - trap and mret together: trap wins, and epc is overwritten before any return.
- rst asserted mid-HALTED or mid-redirect: rst overrides everything on that edge.

## Test plan
- Reset then free-run with RESET_VECTOR = 0: pc_out sequence is 0x0, 0x4, 0x8, 0xC. pc_valid = 1 and flush = 0 throughout.
- Stall and branch:
  - stall held 3 cycles at pc = 0x10: pc_out stays 0x10 for 3 cycles and pc_valid = 0.
  - br_taken with target 0x200 during the stall: flush = 1 that cycle, and pc_out = 0x200 next cycle.
- Trap and return:
  - trap with trap_pc = 0x44 and simultaneous br_taken to 0x80: pc_out = 0x100 and epc = 0x44.
  - later mret: pc_out = 0x44 next cycle, then 0x48.
- Halt and resume:
  - halt at pc = 0x30: halted = 1, pc_valid = 0, pc_out stays 0x30.
  - br_taken while halted: ignored.
  - resume: halted = 0 and fetch resumes at 0x30, then 0x34.
- Misaligned target and wrap:
  - br_target = 0x123: pc_out = 0x120 and misalign pulses for exactly 1 cycle.
  - pc = 0xFFFF_FFFC incrementing: pc_out = 0x0000_0000.
- rst asserted while HALTED with a pending trap: pc_out = RESET_VECTOR, halted = 0, epc = 0.
